// File: rtl/icache_refill_engine_pkg.sv
// Shared types and default geometry for the I-cache refill engine.
package icache_refill_engine_pkg;

  localparam int unsigned DEF_SIZE_PC     = 32;
  localparam int unsigned DEF_CACHE_WIDTH = 256;
  localparam int unsigned DEF_BEAT_WIDTH  = 64;
  localparam int unsigned DEF_LINE_BYTES  = 32;

  localparam int unsigned BEATS      = DEF_CACHE_WIDTH / DEF_BEAT_WIDTH;
  localparam int unsigned BEAT_CNT_W = $clog2(BEATS);
  localparam int unsigned OFFSET_W   = $clog2(DEF_LINE_BYTES);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StResp  = 3'd2,
    StWrite = 3'd3,
    StHold  = 3'd4
  } refill_state_e;

  // Counter width that stays legal for a single-beat line.
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/icache_refill_engine_refill_line_buffer.sv
// Beat counter plus indexed beat write into a full-line register.
module refill_line_buffer
  import icache_refill_engine_pkg::*;
#(
  parameter int unsigned LINE_W = DEF_CACHE_WIDTH,
  parameter int unsigned BEAT_W = DEF_BEAT_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [BEAT_W-1:0] i_data,
  output logic [LINE_W-1:0] o_line,
  output logic              o_last
);

  localparam int unsigned NumBeats = LINE_W / BEAT_W;
  localparam int unsigned CntW     = cnt_width(NumBeats);

  logic [CntW-1:0]   r_count;
  logic [LINE_W-1:0] r_line;

  assign o_line = r_line;
  assign o_last = (r_count == CntW'(NumBeats - 1));

  // Count beats and drop each one into its slot; a clear restarts at beat 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_line  <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      for (int k = 0; k < NumBeats; k++) begin
        if (r_count == CntW'(k)) begin
          r_line[k*BEAT_W +: BEAT_W] <= i_data;
        end
      end
      r_count <= o_last ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/icache_refill_engine.sv
// I-cache miss responder: fetches one line from lower memory and writes it back to L1.
module icache_refill_engine
  import icache_refill_engine_pkg::*;
#(
  parameter int unsigned SIZE_PC     = DEF_SIZE_PC,
  parameter int unsigned CACHE_WIDTH = DEF_CACHE_WIDTH,
  parameter int unsigned BEAT_WIDTH  = DEF_BEAT_WIDTH,
  parameter int unsigned LINE_BYTES  = DEF_LINE_BYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   miss_i,
  input  logic [SIZE_PC-1:0]     missAddr_i,
  output logic                   memReqValid_o,
  input  logic                   memReqReady_i,
  output logic [SIZE_PC-1:0]     memReqAddr_o,
  input  logic                   memRespValid_i,
  input  logic [BEAT_WIDTH-1:0]  memRespData_i,
  output logic                   wrEnable_o,
  output logic [SIZE_PC-1:0]     wrAddr_o,
  output logic [CACHE_WIDTH-1:0] instBlock_o,
  output logic                   busy_o,
  output logic                   protoErr_o
);

  localparam logic [SIZE_PC-1:0] OffsetMask = SIZE_PC'(LINE_BYTES - 1);

  refill_state_e          r_state;
  refill_state_e          w_state_next;
  logic [SIZE_PC-1:0]     r_line_addr;
  logic [SIZE_PC-1:0]     r_wr_addr;
  logic [CACHE_WIDTH-1:0] r_inst_block;
  logic                   r_proto_err;
  logic [CACHE_WIDTH-1:0] w_line;
  logic                   w_req_fire;
  logic                   w_beat_load;
  logic                   w_last;

  assign w_req_fire   = (r_state == StReq) && memReqReady_i;
  assign w_beat_load  = (r_state == StResp) && memRespValid_i;
  assign memReqAddr_o = r_line_addr;
  assign protoErr_o   = r_proto_err;

  refill_line_buffer #(
    .LINE_W (CACHE_WIDTH),
    .BEAT_W (BEAT_WIDTH)
  ) u_line_buffer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_req_fire),
    .i_load  (w_beat_load),
    .i_data  (memRespData_i),
    .o_line  (w_line),
    .o_last  (w_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and decoded outputs; write data is live only in WRITE, held otherwise.
  always_comb begin
    w_state_next  = r_state;
    memReqValid_o = 1'b0;
    wrEnable_o    = 1'b0;
    busy_o        = 1'b1;
    wrAddr_o      = r_wr_addr;
    instBlock_o   = r_inst_block;
    unique case (r_state)
      StIdle: begin
        busy_o = 1'b0;
        if (miss_i) w_state_next = StReq;
      end
      StReq: begin
        memReqValid_o = 1'b1;
        if (memReqReady_i) w_state_next = StResp;
      end
      StResp: begin
        if (memRespValid_i && w_last) w_state_next = StWrite;
      end
      StWrite: begin
        wrEnable_o   = 1'b1;
        wrAddr_o     = r_line_addr;
        instBlock_o  = w_line;
        w_state_next = StHold;
      end
      StHold: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Address latch, held write outputs and the sticky protocol-error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_line_addr  <= '0;
      r_wr_addr    <= '0;
      r_inst_block <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      if ((r_state == StIdle) && miss_i) begin
        r_line_addr <= missAddr_i & ~OffsetMask;
      end
      if (r_state == StWrite) begin
        r_wr_addr    <= r_line_addr;
        r_inst_block <= w_line;
      end
      // Beats arriving in any state other than RESP, including the accept cycle, are errors.
      if (memRespValid_i && (r_state != StResp)) begin
        r_proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_refill_engine.sv
// Self-checking bench: timeline-driven reference model of the refill protocol.
module tb_icache_refill_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic         miss_i;
  logic [31:0]  missAddr_i;
  logic         memReqValid_o;
  logic         memReqReady_i;
  logic [31:0]  memReqAddr_o;
  logic         memRespValid_i;
  logic [63:0]  memRespData_i;
  logic         wrEnable_o;
  logic [31:0]  wrAddr_o;
  logic [255:0] instBlock_o;
  logic         busy_o;
  logic         protoErr_o;

  icache_refill_engine dut (
    .clk            (clk),
    .reset          (reset),
    .miss_i         (miss_i),
    .missAddr_i     (missAddr_i),
    .memReqValid_o  (memReqValid_o),
    .memReqReady_i  (memReqReady_i),
    .memReqAddr_o   (memReqAddr_o),
    .memRespValid_i (memRespValid_i),
    .memRespData_i  (memRespData_i),
    .wrEnable_o     (wrEnable_o),
    .wrAddr_o       (wrAddr_o),
    .instBlock_o    (instBlock_o),
    .busy_o         (busy_o),
    .protoErr_o     (protoErr_o)
  );

  always #5 clk = ~clk;

  // Model state: what the outputs must be in the current cycle.
  bit           chk_en = 1'b0;
  bit           in_resp = 1'b0;
  bit           exp_busy, exp_req, exp_wr, exp_err;
  logic [31:0]  exp_req_addr, exp_wr_addr;
  logic [255:0] exp_line;
  int           n_vec = 0;
  int           n_err = 0;
  int           n_acc = 0;
  logic [31:0]  seen_req_addr = '0;

  function automatic void check(input string name, input logic [255:0] act,
                                input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {255'd0, busy_o}, {255'd0, exp_busy});
      check("req_valid", {255'd0, memReqValid_o}, {255'd0, exp_req});
      if (exp_req) check("req_addr", {224'd0, memReqAddr_o}, {224'd0, exp_req_addr});
      check("wr_en", {255'd0, wrEnable_o}, {255'd0, exp_wr});
      check("wr_addr", {224'd0, wrAddr_o}, {224'd0, exp_wr_addr});
      check("inst_block", instBlock_o, exp_line);
      check("proto_err", {255'd0, protoErr_o}, {255'd0, exp_err});
      if (memReqValid_o && memReqReady_i) n_acc++;
      if (memReqValid_o) seen_req_addr = memReqAddr_o;
    end
  end

  // Advance one cycle and apply the registered effects of this cycle's inputs to the model.
  task automatic tick();
    bit err_now;
    bit rst_now;
    err_now = memRespValid_i && !in_resp;
    rst_now = reset;
    @(posedge clk);
    #1;
    if (rst_now) begin
      exp_err     = 1'b0;
      exp_wr_addr = '0;
      exp_line    = '0;
    end else if (err_now) begin
      exp_err = 1'b1;
    end
  endtask

  task automatic set_exp(input bit busy, input bit req, input bit wr, input bit resp);
    exp_busy = busy;
    exp_req  = req;
    exp_wr   = wr;
    in_resp  = resp;
  endtask

  task automatic idle_cycles(input int n, input bit pulse_err);
    for (int i = 0; i < n; i++) begin
      miss_i         = 1'b0;
      memRespValid_i = pulse_err && (i == 0);
      memRespData_i  = {$urandom, $urandom};
      set_exp(0, 0, 0, 0);
      tick();
    end
    memRespValid_i = 1'b0;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      reset          = 1'b1;
      miss_i         = 1'b0;
      memRespValid_i = 1'b0;
      memReqReady_i  = 1'b0;
      set_exp(0, 0, 0, 0);
      tick();
    end
    reset = 1'b0;
  endtask

  // One miss from an IDLE cycle; rst_after >= 0 resets after that many beats.
  task automatic run_txn(input logic [31:0] addr, input int waits, input int gap,
                         input bit rand_gap, input bit chaos, input int rst_after,
                         input logic [255:0] data);
    logic [31:0] la;
    int          g;
    la = addr & ~32'h1F;
    miss_i         = 1'b1;
    missAddr_i     = addr;
    memRespValid_i = 1'b0;
    memReqReady_i  = 1'($urandom);
    set_exp(0, 0, 0, 0);
    tick();
    for (int w = 0; w <= waits; w++) begin
      memReqReady_i  = (w == waits);
      memRespValid_i = chaos && (w == waits) && ($urandom_range(0, 3) == 0);
      if (chaos) begin
        miss_i     = 1'($urandom);
        missAddr_i = $urandom;
      end
      set_exp(1, 1, 0, 0);
      exp_req_addr = la;
      tick();
    end
    memReqReady_i  = chaos ? 1'($urandom) : 1'b0;
    memRespValid_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b == rst_after) begin
        reset          = 1'b1;
        memRespValid_i = 1'b0;
        set_exp(1, 0, 0, 1);
        tick();
        reset = 1'b0;
        return;
      end
      g = rand_gap ? int'($urandom_range(0, gap)) : gap;
      for (int i = 0; i < g; i++) begin
        memRespValid_i = 1'b0;
        missAddr_i     = chaos ? $urandom : 32'h0000_2000;
        set_exp(1, 0, 0, 1);
        tick();
      end
      memRespValid_i = 1'b1;
      memRespData_i  = data[b*64 +: 64];
      missAddr_i     = chaos ? $urandom : 32'h0000_2000;
      set_exp(1, 0, 0, 1);
      tick();
    end
    memRespValid_i = chaos && ($urandom_range(0, 7) == 0);
    set_exp(1, 0, 1, 0);
    exp_wr_addr = la;
    exp_line    = data;
    tick();
    memRespValid_i = chaos && ($urandom_range(0, 7) == 0);
    if (chaos) miss_i = 1'($urandom);
    set_exp(1, 0, 0, 0);
    tick();
    memRespValid_i = 1'b0;
  endtask

  initial begin
    logic [255:0] d1;
    logic [255:0] d2;
    int           acc0;
    int           ra;
    d1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    d2 = {64'hDDDD_0003_DDDD_0003, 64'hCCCC_0002_CCCC_0002,
          64'hBBBB_0001_BBBB_0001, 64'hAAAA_0000_AAAA_0000};
    reset = 1'b1; miss_i = 1'b0; missAddr_i = '0; memReqReady_i = 1'b0;
    memRespValid_i = 1'b0; memRespData_i = '0;
    exp_err = 0; exp_wr_addr = '0; exp_line = '0; exp_req_addr = '0;
    set_exp(0, 0, 0, 0);
    tick();
    chk_en = 1'b1;
    do_reset(1);
    check("rst_req_addr", {224'd0, memReqAddr_o}, 256'd0);
    check("rst_inst_block", instBlock_o, 256'd0);

    // Fastest refill, then a 5-cycle ready stall issued straight after HOLD with miss held.
    run_txn(32'h0000_104C, 0, 0, 0, 0, -1, d1);
    check("t1_wr_addr", {224'd0, wrAddr_o}, {224'd0, 32'h0000_1040});
    check("t1_line", instBlock_o, d1);
    check("t1_req_addr", {224'd0, seen_req_addr}, {224'd0, 32'h0000_1040});
    acc0 = n_acc;
    run_txn(32'h0000_3008, 5, 0, 0, 0, -1, rand256());
    check("t2_accepts", 256'(n_acc - acc0), 256'd1);
    check("t2_req_addr", {224'd0, seen_req_addr}, {224'd0, 32'h0000_3000});

    // Gapped beats with the miss address moving mid-RESP.
    run_txn(32'h0000_1050, 0, 3, 0, 0, -1, d2);
    check("t3_wr_addr", {224'd0, wrAddr_o}, {224'd0, 32'h0000_1040});
    check("t3_line", instBlock_o, d2);

    // Stray beat in IDLE makes the error stick until reset.
    idle_cycles(2, 1);
    run_txn(32'h0000_0100, 1, 1, 0, 0, -1, rand256());
    check("t5_err_sticky", {255'd0, protoErr_o}, 256'd1);
    do_reset(1);
    check("t5_err_cleared", {255'd0, protoErr_o}, 256'd0);

    // Reset after two beats, then a clean refill.
    run_txn(32'h0000_5000, 0, 0, 0, 0, 2, rand256());
    idle_cycles(2, 0);
    check("t6_wr_addr_reset", {224'd0, wrAddr_o}, 256'd0);
    run_txn(32'h0000_5010, 0, 1, 1, 0, -1, d1);
    check("t6_line", instBlock_o, d1);

    // Top-of-memory line aligns without wrapping the offset.
    run_txn(32'hFFFF_FFFF, 0, 0, 0, 0, -1, rand256());
    check("wrap_req_addr", {224'd0, seen_req_addr}, {224'd0, 32'hFFFF_FFE0});

    for (int t = 0; t < 150; t++) begin
      idle_cycles($urandom_range(0, 3), $urandom_range(0, 7) == 0);
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_txn($urandom, $urandom_range(0, 4), 3, 1, 1, ra, rand256());
      if ($urandom_range(0, 19) == 0) do_reset(1);
    end
    idle_cycles(2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
